// File: rtl/game_timer.sv
// game_timer: two-digit game countdown.
// A prescaler divides clk down to a one-second tick; each tick decrements
// game_duration until it reaches 0, which raises time_up alongside the final tick.
// Control inputs:
//   start - single-cycle request. It always wins: reload, clear the prescaler
//           and run, whatever the current state and whatever pause is doing.
//   pause - level. While high in RUNNING/PAUSED the count is frozen exactly
//           where it is. Resuming continues from the held prescaler value.
// The state and prescaler are exported on dbg_* ports so checkers can observe them.
module game_timer #(
  parameter int unsigned CLK_FREQ_HZ  = 25000000,
  parameter int unsigned GAME_SECONDS = 99
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           pause,
  output logic [6:0]                     game_duration,
  output logic                           running,
  output logic                           tick_1hz,
  output logic                           time_up,
  output logic [1:0]                     dbg_state_o,
  output logic [$clog2(CLK_FREQ_HZ)-1:0] dbg_presc_o
);

  localparam int unsigned PW = $clog2(CLK_FREQ_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ_HZ - 1);
  localparam logic [6:0]    SECS_INIT  = 7'(GAME_SECONDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [6:0]      dur_q, dur_d;
  logic            running_q, running_d;
  logic            tick_q, tick_d;
  logic            up_q, up_d;

  // Next-state, prescaler, counter and event-pulse logic.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dur_d   = dur_q;
    tick_d  = 1'b0;
    up_d    = 1'b0;

    if (start) begin
      // Reload and run; pause is only looked at from the next cycle on.
      state_d = RUNNING;
      presc_d = '0;
      dur_d   = SECS_INIT;
    end else begin
      case (state_q)
        IDLE: begin
          presc_d = '0;
          dur_d   = SECS_INIT;
        end
        RUNNING: begin
          if (pause) begin
            // Freeze before counting: even a terminal prescaler value waits.
            state_d = PAUSED;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (dur_q > 7'd1) begin
              dur_d = dur_q - 7'd1;
            end else begin
              // Final second: land on 0 and stop.
              dur_d   = 7'd0;
              up_d    = 1'b1;
              state_d = EXPIRED;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_d = RUNNING;
          end
        end
        EXPIRED: begin
          dur_d = 7'd0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    running_d = (state_d == RUNNING);
  end

  // State and output registers with asynchronous reset to the idle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      dur_q     <= SECS_INIT;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      up_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      dur_q     <= dur_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      up_q      <= up_d;
    end
  end

  assign game_duration = dur_q;
  assign running       = running_q;
  assign tick_1hz      = tick_q;
  assign time_up       = up_q;
  assign dbg_state_o   = state_q;
  assign dbg_presc_o   = presc_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer (main instance CLK_FREQ_HZ=4, GAME_SECONDS=3),
// plus a default-parameter instance and a CLK_FREQ_HZ=2 / GAME_SECONDS=99 instance.
module tb_game_timer;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_EXP   = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic pause = 1'b0;
  logic start_b = 1'b0;
  logic pause_b = 1'b0;

  logic [6:0]  game_duration;
  logic        running, tick_1hz, time_up;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_presc;

  logic [6:0]  dur_def;
  logic        run_def, tick_def, up_def;
  logic [1:0]  st_def;
  logic [24:0] presc_def;

  logic [6:0]  dur_min;
  logic        run_min, tick_min, up_min;
  logic [1:0]  st_min;
  logic [0:0]  presc_min;

  int n_cmp  = 0;
  int n_fail = 0;

  game_timer #(.CLK_FREQ_HZ(4), .GAME_SECONDS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .game_duration(game_duration), .running(running), .tick_1hz(tick_1hz),
    .time_up(time_up), .dbg_state_o(dbg_state), .dbg_presc_o(dbg_presc)
  );

  game_timer dut_def (
    .clk(clk), .rst(rst), .start(start_b), .pause(pause_b),
    .game_duration(dur_def), .running(run_def), .tick_1hz(tick_def),
    .time_up(up_def), .dbg_state_o(st_def), .dbg_presc_o(presc_def)
  );

  game_timer #(.CLK_FREQ_HZ(2), .GAME_SECONDS(99)) dut_min (
    .clk(clk), .rst(rst), .start(start_b), .pause(pause_b),
    .game_duration(dur_min), .running(run_min), .tick_1hz(tick_min),
    .time_up(up_min), .dbg_state_o(st_min), .dbg_presc_o(presc_min)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; start_b = 1'b0; pause_b = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    // Asserted before any clock edge: values must appear without a clock.
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (game_duration !== 7'd3) begin n_fail++; $display("FAIL reset_dur: got %0d expected 3", game_duration); end
    n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
    n_cmp++; if (tick_1hz !== 1'b0 || time_up !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got tick=%b up=%b expected 0/0", tick_1hz, time_up); end
    n_cmp++; if (dbg_state !== S_IDLE || dbg_presc !== 2'd0) begin n_fail++; $display("FAIL reset_state: got st=%0d presc=%0d expected 0/0", dbg_state, dbg_presc); end
    step();
    rst = 1'b0;
    // Pause in IDLE does nothing.
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++; if (dbg_state !== S_IDLE || game_duration !== 7'd3 || dbg_presc !== 2'd0 || running !== 1'b0) begin
        n_fail++; $display("FAIL idle_hold: got st=%0d dur=%0d presc=%0d run=%b expected 0/3/0/0", dbg_state, game_duration, dbg_presc, running);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_countdown();
    logic [6:0] exp_dur [12] = '{7'd3, 7'd3, 7'd3, 7'd2, 7'd2, 7'd2, 7'd2, 7'd1, 7'd1, 7'd1, 7'd1, 7'd0};
    logic       exp_tick[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_up  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_run [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (running !== 1'b1 || game_duration !== 7'd3 || dbg_presc !== 2'd0 || tick_1hz !== 1'b0) begin
      n_fail++; $display("FAIL cd_start: got run=%b dur=%0d presc=%0d tick=%b expected 1/3/0/0", running, game_duration, dbg_presc, tick_1hz);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      n_cmp++; if (game_duration !== exp_dur[k]) begin n_fail++; $display("FAIL cd_dur[%0d]: got %0d expected %0d", k + 1, game_duration, exp_dur[k]); end
      n_cmp++; if (tick_1hz !== exp_tick[k]) begin n_fail++; $display("FAIL cd_tick[%0d]: got %b expected %b", k + 1, tick_1hz, exp_tick[k]); end
      n_cmp++; if (time_up !== exp_up[k]) begin n_fail++; $display("FAIL cd_up[%0d]: got %b expected %b", k + 1, time_up, exp_up[k]); end
      n_cmp++; if (running !== exp_run[k]) begin n_fail++; $display("FAIL cd_run[%0d]: got %b expected %b", k + 1, running, exp_run[k]); end
    end
    n_cmp++; if (dbg_state !== S_EXP) begin n_fail++; $display("FAIL cd_expired: got st=%0d expected 3", dbg_state); end
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++; if (game_duration !== 7'd0 || tick_1hz !== 1'b0 || time_up !== 1'b0 || running !== 1'b0 || dbg_state !== S_EXP) begin
        n_fail++; $display("FAIL exp_hold: got dur=%0d tick=%b up=%b run=%b st=%0d expected 0/0/0/0/3", game_duration, tick_1hz, time_up, running, dbg_state);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_cmp++; if (dbg_presc !== 2'd2) begin n_fail++; $display("FAIL pause_pre_presc: got %0d expected 2", dbg_presc); end
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++; if (game_duration !== 7'd3 || tick_1hz !== 1'b0 || dbg_state !== S_PAUSE || running !== 1'b0 || dbg_presc !== 2'd2) begin
        n_fail++; $display("FAIL pause_hold[%0d]: got dur=%0d tick=%b st=%0d run=%b presc=%0d expected 3/0/2/0/2", k, game_duration, tick_1hz, dbg_state, running, dbg_presc);
      end
    end
    pause = 1'b0;
    step();
    n_cmp++; if (dbg_state !== S_RUN || running !== 1'b1 || dbg_presc !== 2'd2 || tick_1hz !== 1'b0) begin
      n_fail++; $display("FAIL pause_resume: got st=%0d run=%b presc=%0d tick=%b expected 1/1/2/0", dbg_state, running, dbg_presc, tick_1hz);
    end
    step();
    n_cmp++; if (game_duration !== 7'd3 || tick_1hz !== 1'b0) begin n_fail++; $display("FAIL pause_r1: got dur=%0d tick=%b expected 3/0", game_duration, tick_1hz); end
    step();
    n_cmp++; if (game_duration !== 7'd2 || tick_1hz !== 1'b1 || dbg_presc !== 2'd0) begin
      n_fail++; $display("FAIL pause_r2: got dur=%0d tick=%b presc=%0d expected 2/1/0", game_duration, tick_1hz, dbg_presc);
    end
  endtask

  task automatic test_pause_terminal();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    n_cmp++; if (dbg_presc !== 2'd3) begin n_fail++; $display("FAIL pt_presc: got %0d expected 3", dbg_presc); end
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (tick_1hz !== 1'b0 || game_duration !== 7'd3 || dbg_presc !== 2'd3 || dbg_state !== S_PAUSE) begin
        n_fail++; $display("FAIL pt_hold[%0d]: got tick=%b dur=%0d presc=%0d st=%0d expected 0/3/3/2", k, tick_1hz, game_duration, dbg_presc, dbg_state);
      end
    end
    pause = 1'b0;
    step();
    n_cmp++; if (tick_1hz !== 1'b0 || dbg_state !== S_RUN || game_duration !== 7'd3) begin
      n_fail++; $display("FAIL pt_resume: got tick=%b st=%0d dur=%0d expected 0/1/3", tick_1hz, dbg_state, game_duration);
    end
    step();
    n_cmp++; if (tick_1hz !== 1'b1 || game_duration !== 7'd2 || dbg_presc !== 2'd0) begin
      n_fail++; $display("FAIL pt_tick: got tick=%b dur=%0d presc=%0d expected 1/2/0", tick_1hz, game_duration, dbg_presc);
    end
  endtask

  task automatic test_restart();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) step();
    n_cmp++; if (game_duration !== 7'd1 || tick_1hz !== 1'b1) begin n_fail++; $display("FAIL rs_at1: got dur=%0d tick=%b expected 1/1", game_duration, tick_1hz); end
    step(); step(); step();
    n_cmp++; if (dbg_presc !== 2'd3) begin n_fail++; $display("FAIL rs_presc3: got %0d expected 3", dbg_presc); end
    // start lands on what would have been the final tick: reload wins.
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (game_duration !== 7'd3 || dbg_presc !== 2'd0 || tick_1hz !== 1'b0 || time_up !== 1'b0 || running !== 1'b1 || dbg_state !== S_RUN) begin
      n_fail++; $display("FAIL rs_run: got dur=%0d presc=%0d tick=%b up=%b run=%b st=%0d expected 3/0/0/0/1/1", game_duration, dbg_presc, tick_1hz, time_up, running, dbg_state);
    end
    for (int k = 0; k < 14; k++) step();
    n_cmp++; if (dbg_state !== S_EXP || game_duration !== 7'd0) begin n_fail++; $display("FAIL rs_expire: got st=%0d dur=%0d expected 3/0", dbg_state, game_duration); end
    // Restart from EXPIRED with pause held: start still wins this cycle.
    start = 1'b1;
    pause = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (dbg_state !== S_RUN || game_duration !== 7'd3 || dbg_presc !== 2'd0 || running !== 1'b1) begin
      n_fail++; $display("FAIL rs_from_exp: got st=%0d dur=%0d presc=%0d run=%b expected 1/3/0/1", dbg_state, game_duration, dbg_presc, running);
    end
    step();
    n_cmp++; if (dbg_state !== S_PAUSE || running !== 1'b0 || game_duration !== 7'd3) begin
      n_fail++; $display("FAIL rs_then_pause: got st=%0d run=%b dur=%0d expected 2/0/3", dbg_state, running, game_duration);
    end
    pause = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    pause = 1'b1;
    step();
    n_cmp++; if (dbg_state !== S_PAUSE || game_duration !== 7'd2) begin n_fail++; $display("FAIL ar_setup: got st=%0d dur=%0d expected 2/2", dbg_state, game_duration); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (game_duration !== 7'd3 || running !== 1'b0 || tick_1hz !== 1'b0 || time_up !== 1'b0 || dbg_state !== S_IDLE || dbg_presc !== 2'd0) begin
      n_fail++; $display("FAIL ar_async: got dur=%0d run=%b tick=%b up=%b st=%0d presc=%0d expected 3/0/0/0/0/0", game_duration, running, tick_1hz, time_up, dbg_state, dbg_presc);
    end
    start = 1'b1;
    pause = 1'b0;
    step();
    step();
    n_cmp++; if (dbg_state !== S_IDLE || running !== 1'b0 || game_duration !== 7'd3) begin
      n_fail++; $display("FAIL ar_start_ignored: got st=%0d run=%b dur=%0d expected 0/0/3", dbg_state, running, game_duration);
    end
    start = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step();
    n_cmp++; if (dbg_state !== S_IDLE || running !== 1'b0 || game_duration !== 7'd3 || dbg_presc !== 2'd0) begin
      n_fail++; $display("FAIL ar_wait_idle: got st=%0d run=%b dur=%0d presc=%0d expected 0/0/3/0", dbg_state, running, game_duration, dbg_presc);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (running !== 1'b1 || game_duration !== 7'd3) begin n_fail++; $display("FAIL ar_restart: got run=%b dur=%0d expected 1/3", running, game_duration); end
  endtask

  task automatic test_defaults();
    logic [6:0] exp_min [6] = '{7'd99, 7'd98, 7'd98, 7'd97, 7'd97, 7'd96};
    logic       exp_tk  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    n_cmp++; if (dur_def !== 7'd99 || dur_min !== 7'd99) begin n_fail++; $display("FAIL def_reset: got def=%0d min=%0d expected 99/99", dur_def, dur_min); end
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    n_cmp++; if (run_def !== 1'b1 || dur_def !== 7'd99 || run_min !== 1'b1 || dur_min !== 7'd99) begin
      n_fail++; $display("FAIL def_start: got run_def=%b def=%0d run_min=%b min=%0d expected 1/99/1/99", run_def, dur_def, run_min, dur_min);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++; if (dur_min !== exp_min[k] || tick_min !== exp_tk[k]) begin
        n_fail++; $display("FAIL min_step[%0d]: got dur=%0d tick=%b expected %0d/%b", k + 1, dur_min, tick_min, exp_min[k], exp_tk[k]);
      end
    end
    for (int k = 0; k < 40; k++) begin
      step();
      n_cmp++; if (dur_def !== 7'd99 || tick_def !== 1'b0 || dur_min > 7'd99) begin
        n_fail++; $display("FAIL def_hold[%0d]: got def=%0d tick=%b min=%0d expected 99/0/<=99", k, dur_def, tick_def, dur_min);
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_pause_terminal();
    test_restart();
    test_async_reset();
    test_defaults();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 25000000, meaning clk cycles per one-second tick; legal range is 2 or more.
REQ-002 The block SHALL have parameter GAME_SECONDS, default 99, meaning the countdown start value; legal range is 1..99, fitting the two-digit display.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to load GAME_SECONDS and run.
REQ-006 The block SHALL have port pause, input, 1 bit: a level; while high, the countdown is frozen.
REQ-007 The block SHALL have port game_duration, output, 7 bits: the remaining seconds (0..99), registered, consumed by the digit renderer.
REQ-008 The block SHALL have port running, output, 1 bit: high exactly while state = RUNNING.
REQ-009 The block SHALL have port tick_1hz, output, 1 bit: a one-cycle pulse on each second decrement.
REQ-010 The block SHALL have port time_up, output, 1 bit: a one-cycle pulse when game_duration reaches 0.

Function
REQ-011 The block SHALL implement a state machine with exactly four states: IDLE, RUNNING, PAUSED, EXPIRED.
REQ-012 The block SHALL hold a prescaler counter of width $clog2(CLK_FREQ_HZ) that counts 0..CLK_FREQ_HZ-1.
REQ-013 In IDLE, the block SHALL hold game_duration = GAME_SECONDS and hold the prescaler at 0.
REQ-014 In any state, start = 1 SHALL cause the following on the next edge:
- game_duration = GAME_SECONDS
- prescaler = 0
- state = RUNNING
- tick_1hz = 0 and time_up = 0, regardless of pause.
REQ-015 start SHALL have priority over all other conditions; pause is evaluated from the cycle after start onward.
REQ-016 In RUNNING with pause = 1, the next state SHALL be PAUSED, the prescaler SHALL hold, and no tick SHALL occur that cycle, even if the prescaler is at CLK_FREQ_HZ-1.
REQ-017 In RUNNING with pause = 0, the prescaler SHALL increment by 1 each cycle.
REQ-018 When the prescaler equals CLK_FREQ_HZ-1 in RUNNING with pause = 0:
- the prescaler wraps to 0
- game_duration decrements by 1
- tick_1hz is 1 for the cycle following that edge.
REQ-019 When that decrement takes game_duration from 1 to 0:
- the next state is EXPIRED
- time_up pulses in the same cycle as that tick_1hz.
REQ-020 In PAUSED, the prescaler and game_duration SHALL hold; pause = 0 SHALL return to RUNNING, resuming from the held prescaler value with no loss or gain of cycles.
REQ-021 In EXPIRED, game_duration SHALL hold at 0, with no further tick_1hz or time_up; only start leaves EXPIRED.
REQ-022 game_duration SHALL never underflow below 0 and never exceed GAME_SECONDS.
REQ-023 tick_1hz and time_up SHALL be registered and SHALL be high for exactly one cycle per event.
REQ-024 running SHALL be registered and SHALL be 1 in every cycle where state = RUNNING, including the start cycle's successor.

Reset
REQ-025 Assertion of rst SHALL immediately, without waiting for clk, force:
- state = IDLE
- prescaler = 0
- game_duration = GAME_SECONDS
- running = 0, tick_1hz = 0, time_up = 0.
REQ-026 rst asserted mid-count, in PAUSED or in EXPIRED SHALL discard all progress; after release the block SHALL wait in IDLE for start.
REQ-027 start SHALL be ignored while rst = 1.

Verification (CLK_FREQ_HZ=4, GAME_SECONDS=3 unless stated)
REQ-028 Basic countdown: rst, then start pulse -> running = 1; game_duration shows 3, 2, 1, 0, changing every 4 cycles; tick_1hz pulses 3 times; time_up pulses once, coincident with the tick that reaches 0; then state = EXPIRED and running = 0.
REQ-029 Pause: pause high for 10 cycles after 2 running cycles -> game_duration stays 3 throughout; after pause falls, the next decrement occurs exactly 2 running cycles later.
REQ-030 Pause on terminal count: pause rises in the cycle the prescaler = 3 -> no tick, game_duration unchanged; the tick occurs on the first running cycle after pause falls.
REQ-031 Restart: start while game_duration = 1 in RUNNING -> next cycle game_duration = 3 and prescaler = 0; likewise from EXPIRED -> RUNNING with 3.
REQ-032 Async reset: assert rst between clk edges while PAUSED with game_duration = 2 -> outputs equal reset values before the next edge; start pulses while rst is high have no effect.
REQ-033 Defaults: CLK_FREQ_HZ=25000000, GAME_SECONDS=99, checked with a forced prescaler -> game_duration steps 99 -> 98, and the 7-bit output never exceeds 99.
